// File: rtl/hook_pkg.sv
// hook_pkg
// Shared definitions for the Gold Miner hook path: state encodings and
// the default game constants. drawcon and hook_moving use the same values.
// No ports; import with "import hook_pkg::*;".
package hook_pkg;

    // Default game constants
    localparam int ANG_STEPS   = 32;   // discrete swing angles, 0..ANG_STEPS-1
    localparam int SWING_DIV   = 2;    // frames per angle step
    localparam int LEN_MIN     = 16;   // resting rope length, px
    localparam int LEN_MAX     = 400;  // fully extended rope length, px
    localparam int EXT_SPEED   = 4;    // px per frame while extending
    localparam int RET_EMPTY   = 6;    // px per frame retracting, no load
    localparam int RET_LOADED  = 2;    // px per frame retracting, loaded
    localparam int DUMP_FRAMES = 30;   // frames spent in DUMP before scoring

    // Datapath widths
    localparam int ANG_W   = 5;        // hook_ang width
    localparam int LEN_W   = 10;       // hook_len width
    localparam int ARITH_W = 11;       // length arithmetic is done one bit wider
    localparam int CNT_W   = 8;        // swing / dump frame counters

    typedef enum logic [1:0] {
        ST_SWING   = 2'd0,
        ST_EXTEND  = 2'd1,
        ST_RETRACT = 2'd2,
        ST_DUMP    = 2'd3
    } hook_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer followed by a rising-edge detector for a raw
// asynchronous player button. Shared by the fire button and the other
// player buttons.
//
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_din   : raw asynchronous input
//   o_rise  : high for one i_clk cycle after the synchronized input rises
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_din;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    // Combinational edge: the consumer registers it on the next edge, which
    // gives three clocks from the raw input to the consumer's flop.
    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/hook_ctrl.sv
// hook_ctrl
// Frame-rate sequencer for the Gold Miner hook. Swings the hook angle,
// extends on a fire press, grabs on a collision, retracts at a
// load-dependent speed and issues a one-cycle score pulse after dumping
// the load. All state/angle/length updates happen on the frame tick
// derived from the falling edge of vsync; only fire capture is per-cycle.
//
// Ports:
//   clk         : pixel clock
//   rst         : asynchronous active-low reset
//   vsync       : VGA vertical sync (active-low pulse), same clock domain
//   fire        : raw player fire button, asynchronous to clk
//   hit         : high while the hook tip overlaps an object
//   hook_ang    : current angle index
//   hook_len    : current rope length, px
//   hook_state  : SWING=0, EXTEND=1, RETRACT=2, DUMP=3
//   grabbed     : an object is attached to the hook
//   score_pulse : one-cycle pulse when a load is delivered
module hook_ctrl
    import hook_pkg::*;
#(
    parameter int ANG_STEPS   = hook_pkg::ANG_STEPS,
    parameter int SWING_DIV   = hook_pkg::SWING_DIV,
    parameter int LEN_MIN     = hook_pkg::LEN_MIN,
    parameter int LEN_MAX     = hook_pkg::LEN_MAX,
    parameter int EXT_SPEED   = hook_pkg::EXT_SPEED,
    parameter int RET_EMPTY   = hook_pkg::RET_EMPTY,
    parameter int RET_LOADED  = hook_pkg::RET_LOADED,
    parameter int DUMP_FRAMES = hook_pkg::DUMP_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             fire,
    input  logic             hit,
    output logic [ANG_W-1:0] hook_ang,
    output logic [LEN_W-1:0] hook_len,
    output logic [1:0]       hook_state,
    output logic             grabbed,
    output logic             score_pulse
);

    // Frame tick
    logic r_vs_smp;     // vsync sampled this edge
    logic r_vs_prev;    // vsync sampled one edge earlier
    logic r_tick;       // one-cycle frame tick

    // Reset value 0 on both samples: a low or high vsync out of reset never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_smp  <= 1'b0;
            r_vs_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vs_smp  <= vsync;
            r_vs_prev <= r_vs_smp;
            r_tick    <= r_vs_prev & ~r_vs_smp;
        end
    end

    // Fire capture
    logic w_fire_rise;

    sync_edge u_fire_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_din   (fire),
        .o_rise  (w_fire_rise)
    );

    // Main sequencer state
    hook_state_t      r_state;
    logic [ANG_W-1:0] r_ang;
    logic             r_dir_up;     // 1: angle increasing, 0: decreasing
    logic [CNT_W-1:0] r_swing_cnt;
    logic [CNT_W-1:0] r_dump_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_grabbed;
    logic             r_fire_pend;
    logic             r_score;

    // Length arithmetic, one bit wider than the length so the extend sum
    // cannot wrap before saturation.
    logic [ARITH_W-1:0] w_len_wide;
    logic [ARITH_W-1:0] w_len_ext;
    logic [ARITH_W-1:0] w_len_ext_sat;
    logic [ARITH_W-1:0] w_ret_step;
    logic [ARITH_W-1:0] w_len_ret_sat;
    logic               w_ext_at_max;
    logic               w_ret_at_min;

    assign w_len_wide    = ARITH_W'(r_len);
    assign w_len_ext     = w_len_wide + ARITH_W'(EXT_SPEED);
    assign w_len_ext_sat = (w_len_ext >= ARITH_W'(LEN_MAX)) ? ARITH_W'(LEN_MAX) : w_len_ext;
    assign w_ext_at_max  = (w_len_ext_sat == ARITH_W'(LEN_MAX));

    assign w_ret_step    = r_grabbed ? ARITH_W'(RET_LOADED) : ARITH_W'(RET_EMPTY);
    // Compare before subtracting so the result never underflows.
    assign w_len_ret_sat = (w_len_wide <= ARITH_W'(LEN_MIN) + w_ret_step)
                           ? ARITH_W'(LEN_MIN) : (w_len_wide - w_ret_step);
    assign w_ret_at_min  = (w_len_ret_sat == ARITH_W'(LEN_MIN));

    // Swing boundary detection
    logic w_swing_wrap;
    logic w_at_top;
    logic w_at_bot;

    assign w_swing_wrap = (r_swing_cnt == CNT_W'(SWING_DIV - 1));
    assign w_at_top     = (r_ang == ANG_W'(ANG_STEPS - 1));
    assign w_at_bot     = (r_ang == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SWING;
            r_ang       <= ANG_W'(ANG_STEPS / 2);
            r_dir_up    <= 1'b1;
            r_swing_cnt <= '0;
            r_dump_cnt  <= '0;
            r_len       <= LEN_W'(LEN_MIN);
            r_grabbed   <= 1'b0;
            r_fire_pend <= 1'b0;
            r_score     <= 1'b0;
        end else begin
            r_score <= 1'b0;

            // Presses outside SWING are dropped. A press landing on the same
            // cycle as a SWING tick is kept for the following tick.
            if (w_fire_rise && (r_state == ST_SWING)) begin
                r_fire_pend <= 1'b1;
            end

            if (r_tick) begin
                case (r_state)
                    ST_SWING: begin
                        if (r_fire_pend) begin
                            // Angle frozen on the launch tick.
                            r_state     <= ST_EXTEND;
                            r_fire_pend <= 1'b0;
                        end else if (w_swing_wrap) begin
                            r_swing_cnt <= '0;
                            // At an end stop the step period is spent turning
                            // around, so the end angle is held one extra period.
                            if (r_dir_up && w_at_top) begin
                                r_dir_up <= 1'b0;
                            end else if (!r_dir_up && w_at_bot) begin
                                r_dir_up <= 1'b1;
                            end else if (r_dir_up) begin
                                r_ang <= r_ang + 1'b1;
                            end else begin
                                r_ang <= r_ang - 1'b1;
                            end
                        end else begin
                            r_swing_cnt <= r_swing_cnt + 1'b1;
                        end
                    end

                    ST_EXTEND: begin
                        // Collision wins over growth on the same tick.
                        if (hit) begin
                            r_grabbed <= 1'b1;
                            r_state   <= ST_RETRACT;
                        end else begin
                            r_len <= LEN_W'(w_len_ext_sat);
                            if (w_ext_at_max) begin
                                r_grabbed <= 1'b0;
                                r_state   <= ST_RETRACT;
                            end
                        end
                    end

                    ST_RETRACT: begin
                        r_len <= LEN_W'(w_len_ret_sat);
                        if (w_ret_at_min) begin
                            if (r_grabbed) begin
                                r_state    <= ST_DUMP;
                                r_dump_cnt <= '0;
                            end else begin
                                r_state     <= ST_SWING;
                                r_swing_cnt <= '0;
                            end
                        end
                    end

                    ST_DUMP: begin
                        if (r_dump_cnt == CNT_W'(DUMP_FRAMES - 1)) begin
                            r_score     <= 1'b1;
                            r_grabbed   <= 1'b0;
                            r_state     <= ST_SWING;
                            r_swing_cnt <= '0;
                            r_dump_cnt  <= '0;
                        end else begin
                            r_dump_cnt <= r_dump_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_SWING;
                    end
                endcase
            end
        end
    end

    assign hook_ang    = r_ang;
    assign hook_len    = r_len;
    assign hook_state  = r_state;
    assign grabbed     = r_grabbed;
    assign score_pulse = r_score;

endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl
// Frame-level bench for hook_ctrl. Each frame optionally presses fire and
// sets hit, then issues one vsync pulse; a reference model advances once
// per frame and its predicted outputs go through an expected queue.
module tb_hook_ctrl;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       fire;
    logic       hit;
    logic [4:0] hook_ang;
    logic [9:0] hook_len;
    logic [1:0] hook_state;
    logic       grabbed;
    logic       score_pulse;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    hook_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .fire        (fire),
        .hit         (hit),
        .hook_ang    (hook_ang),
        .hook_len    (hook_len),
        .hook_state  (hook_state),
        .grabbed     (grabbed),
        .score_pulse (score_pulse)
    );

    // Scoreboard
    localparam int EW = 19;          // {state2, ang5, len10, grab1, pulse1}
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int pulse_total = 0;             // score_pulse high cycles seen

    always @(posedge clk) begin
        if (score_pulse) pulse_total <= pulse_total + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference model
    int m_state, m_ang, m_dir, m_cnt, m_len, m_grab, m_pend, m_dump, m_pulse;

    task automatic model_reset();
        m_state = 0; m_ang = 16; m_dir = 1; m_cnt = 0; m_len = 16;
        m_grab = 0; m_pend = 0; m_dump = 0; m_pulse = 0;
    endtask

    task automatic model_tick(input bit h);
        m_pulse = 0;
        case (m_state)
            0: begin
                if (m_pend == 1) begin
                    m_pend = 0;
                    m_state = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 2) begin
                        m_cnt = 0;
                        if (m_ang + m_dir > 31 || m_ang + m_dir < 0) m_dir = -m_dir;
                        else m_ang = m_ang + m_dir;
                    end
                end
            end
            1: begin
                if (h) begin
                    m_grab = 1;
                    m_state = 2;
                end else begin
                    m_len = m_len + 4;
                    if (m_len >= 400) begin
                        m_len = 400;
                        m_grab = 0;
                        m_state = 2;
                    end
                end
            end
            2: begin
                m_len = m_len - ((m_grab == 1) ? 2 : 6);
                if (m_len <= 16) begin
                    m_len = 16;
                    if (m_grab == 1) begin
                        m_state = 3;
                        m_dump = 0;
                    end else begin
                        m_state = 0;
                        m_cnt = 0;
                    end
                end
            end
            default: begin
                m_dump = m_dump + 1;
                if (m_dump == 30) begin
                    m_pulse = 1;
                    m_grab = 0;
                    m_state = 0;
                    m_cnt = 0;
                end
            end
        endcase
    endtask

    // Driver tasks
    task automatic run_frame(input bit do_fire, input bit h);
        int p0;
        logic [EW-1:0] e;
        p0 = pulse_total;
        hit = h;
        if (do_fire) begin
            if (m_state == 0) m_pend = 1;
            fire = 1'b1;
        end
        repeat (4) @(negedge clk);
        fire = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        model_tick(h);
        exp_q.push_back({2'(m_state), 5'(m_ang), 10'(m_len), 1'(m_grab), 1'(m_pulse)});
        @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        chk("state", int'(hook_state), int'(e[18:17]));
        chk("ang",   int'(hook_ang),   int'(e[16:12]));
        chk("len",   int'(hook_len),   int'(e[11:2]));
        chk("grab",  int'(grabbed),    int'(e[1]));
        chk("pulse", pulse_total - p0, int'(e[0]));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, int'(hook_state), 0);
        chk({tag, "_ang"},   int'(hook_ang),   16);
        chk({tag, "_len"},   int'(hook_len),   16);
        chk({tag, "_grab"},  int'(grabbed),    0);
        chk({tag, "_pulse"}, int'(score_pulse), 0);
    endtask

    initial begin
        int n;
        int saw_max;
        int p0;
        rst = 1'b0; vsync = 1'b1; fire = 1'b0; hit = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Free swing: up to 31, hold one step period, then descend
        for (int i = 0; i < 40; i++) begin
            run_frame(1'b0, 1'b0);
            if (i == 29) chk("ang_top", int'(hook_ang), 31);
            if (i == 31) chk("ang_hold", int'(hook_ang), 31);
            if (i == 33) chk("ang_down", int'(hook_ang), 30);
        end
        chk("swing_len", int'(hook_len), 16);

        // Swing to angle 20, then fire
        n = 0;
        while (m_ang != 20 && n < 100) begin
            run_frame(1'b0, 1'b0);
            n++;
        end
        chk("ang20", int'(hook_ang), 20);
        run_frame(1'b1, 1'b0);
        chk("launch_state", int'(hook_state), 1);
        run_frame(1'b0, 1'b0);
        chk("launch_len", int'(hook_len), 20);
        chk("launch_ang", int'(hook_ang), 20);

        // Empty extend to LEN_MAX and back, random ignored fire presses
        n = 0; saw_max = 0; p0 = pulse_total;
        while (m_state != 0 && n < 400) begin
            run_frame($urandom_range(0, 3) == 0, 1'b0);
            if (hook_len == 10'd400) saw_max = 1;
            n++;
        end
        chk("saw_max", saw_max, 1);
        chk("empty_pulse", pulse_total - p0, 0);
        for (int i = 0; i < 6; i++) run_frame(1'b0, 1'b0);
        chk("no_extra_ext", int'(hook_state), 0);

        // Grab on the tick where length would reach LEN_MAX
        run_frame(1'b1, 1'b0);
        n = 0;
        while (m_len < 396 && n < 200) begin
            run_frame(1'b0, 1'b0);
            n++;
        end
        run_frame(1'b0, 1'b1);
        chk("grab_flag", int'(grabbed), 1);
        chk("grab_len", int'(hook_len), 396);
        run_frame(1'b0, 1'b1);
        chk("loaded_step", int'(hook_len), 394);
        p0 = pulse_total;
        n = 0;
        while (m_state != 0 && n < 400) begin
            run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            n++;
        end
        chk("score_once", pulse_total - p0, 1);
        for (int i = 0; i < 6; i++) run_frame(1'b0, 1'b0);
        chk("after_dump", int'(hook_state), 0);

        // Reset while retracting loaded
        run_frame(1'b1, 1'b0);
        n = 0;
        while (m_len < 100 && n < 100) begin
            run_frame(1'b0, 1'b0);
            n++;
        end
        run_frame(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b0);
        chk("pre_rst_grab", int'(grabbed), 1);
        p0 = pulse_total;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset("mid_rst");
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) run_frame(1'b0, 1'b0);
        chk("rst_no_pulse", pulse_total - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
